multdiv_unit: RTL and testbench

Iterative signed multiply/divide unit in the execute stage, directly downstream of the DX pipeline latch. It consumes the latched operands `DX_A`/`DX_B` and one-cycle `mult`/`div` start pulses decoded from `DX_IR`. While an operation is in flight it raises `stall`, which freezes PC, FD and DX through their `en` inputs. It returns a 32-bit result plus an exception flag for the XM latch.

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/adder_32.sv | 18 +
 rtl/multdiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: FSM encoding,
// iteration count and the ALU opcodes that decode into the start pulses.
package multdiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam logic [4:0] ALU_OP_MULT = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV  = 5'b00111;

    // Counter value seen on the cycle that performs the final iteration.
    function automatic logic [CNT_W-1:0] last_iter(input int iter);
        return CNT_W'(iter - 1);
    endfunction

endpackage

// File: rtl/adder_32.sv
// Add/subtract with carry-out; sub=1 computes a - b as a + ~b + 1, so cout=1
// means "no borrow" (a >= b unsigned).
module adder_32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] b_eff;

    assign b_eff       = b ^ {W{sub}};
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide unit that
// stalls the front of the pipeline while an operation is in flight.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = multdiv_pkg::ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_ready,
    output logic             stall
);
    import multdiv_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = last_iter(ITER);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] opnd_reg, opnd_next;
    logic             qm1_reg, qm1_next;
    logic             neg_reg, neg_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             exc_reg, exc_next;

    logic [WIDTH-1:0] step_a, step_b, step_sum;
    logic             step_sub, step_cout;

    logic [1:0][WIDTH-1:0] neg_in, neg_out;
    logic [1:0]            neg_zero;

    logic [WIDTH-1:0] mul_hi, mul_lo, div_rem, div_quo, div_res;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             mul_sign, a_is_min, div_ovf, b_zero;

    // One adder serves both iteration kinds: Booth add/sub of the
    // multiplicand into the high word, or the divide trial subtract.
    always_comb begin
        step_a   = hi_reg;
        step_b   = '0;
        step_sub = 1'b0;
        if (state_reg == ST_DIV) begin
            step_a   = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
            step_b   = opnd_reg;
            step_sub = 1'b1;
        end else begin
            case ({lo_reg[0], qm1_reg})
                2'b01:   step_b = opnd_reg;
                2'b10: begin
                    step_b   = opnd_reg;
                    step_sub = 1'b1;
                end
                default: step_b = '0;
            endcase
        end
    end

    adder_32 #(.W(WIDTH)) u_step (
        .a    (step_a),
        .b    (step_b),
        .sub  (step_sub),
        .sum  (step_sum),
        .cout (step_cout)
    );

    // Bit 32 of the sign-extended sum, so the arithmetic shift never loses
    // the sign when hi +/- A overflows 32 bits.
    assign mul_sign = hi_reg[WIDTH-1] ^ step_b[WIDTH-1] ^ step_sub ^ step_cout;
    assign mul_hi   = {mul_sign, step_sum[WIDTH-1:1]};
    assign mul_lo   = {step_sum[0], lo_reg[WIDTH-1:1]};

    assign div_rem  = step_cout ? step_sum : step_a;
    assign div_quo  = {lo_reg[WIDTH-2:0], step_cout};

    // Negators: slot 0 takes |A| at start and the quotient sign fix on the
    // last divide step; slot 1 takes |B|. cout of 0 - x flags x == 0.
    assign neg_in[0] = (state_reg == ST_IDLE) ? data_operandA : div_quo;
    assign neg_in[1] = data_operandB;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_neg
            adder_32 #(.W(WIDTH)) u_neg (
                .a    ({WIDTH{1'b0}}),
                .b    (neg_in[gi]),
                .sub  (1'b1),
                .sum  (neg_out[gi]),
                .cout (neg_zero[gi])
            );
        end
    endgenerate

    assign a_abs    = data_operandA[WIDTH-1] ? neg_out[0] : data_operandA;
    assign b_abs    = data_operandB[WIDTH-1] ? neg_out[1] : data_operandB;
    // The only nonzero value equal to its own negation is the most negative.
    assign a_is_min = (neg_out[0] == data_operandA) && !neg_zero[0];
    assign div_ovf  = a_is_min && (&data_operandB);
    assign b_zero   = neg_zero[1];
    assign div_res  = neg_reg ? neg_out[0] : div_quo;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        opnd_next   = opnd_reg;
        qm1_next    = qm1_reg;
        neg_next    = neg_reg;
        ovf_next    = ovf_reg;
        result_next = result_reg;
        exc_next    = exc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!flush && ctrl_MULT) begin
                    state_next = ST_MUL;
                    cnt_next   = '0;
                    hi_next    = '0;
                    lo_next    = data_operandB;
                    qm1_next   = 1'b0;
                    opnd_next  = data_operandA;
                end else if (!flush && ctrl_DIV) begin
                    if (b_zero) begin
                        state_next  = ST_DONE;
                        result_next = '0;
                        exc_next    = 1'b1;
                    end else begin
                        state_next = ST_DIV;
                        cnt_next   = '0;
                        hi_next    = '0;
                        lo_next    = a_abs;
                        opnd_next  = b_abs;
                        neg_next   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        ovf_next   = div_ovf;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    hi_next  = mul_hi;
                    lo_next  = mul_lo;
                    qm1_next = lo_reg[0];
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_next  = ST_DONE;
                        result_next = mul_lo;
                        exc_next    = (mul_hi != {WIDTH{mul_lo[WIDTH-1]}});
                    end
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    hi_next  = div_rem;
                    lo_next  = div_quo;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_next  = ST_DONE;
                        result_next = div_res;
                        exc_next    = ovf_reg;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
            qm1_reg    <= 1'b0;
            neg_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            opnd_reg   <= opnd_next;
            qm1_reg    <= qm1_next;
            neg_reg    <= neg_next;
            ovf_reg    <= ovf_next;
            result_reg <= result_next;
            exc_reg    <= exc_next;
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_ready     = (state_reg == ST_DONE);
    assign stall          = (state_reg == ST_MUL) || (state_reg == ST_DIV) ||
                            ((state_reg == ST_IDLE) && !flush && (ctrl_MULT || ctrl_DIV));

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table plus random model-checked
// operations through a result scoreboard, then reset/flush/start-collision cases.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_ready;
    logic        stall;

    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .flush          (flush),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_ready     (data_ready),
        .stall          (stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mul;
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          stl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mul, input logic div, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res, input logic exc);
        vec_t v;
        v.mul = mul; v.div = div; v.a = a; v.b = b; v.res = res; v.exc = exc;
        v.lat = (div && !mul && b == 32'h0) ? 0 : 32;
        v.stl = (div && !mul && b == 32'h0) ? 1 : 33;
        return v;
    endfunction

    // Reference arithmetic done in 64-bit signed integers.
    function automatic exp_t model(input logic mul, input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        longint p;
        logic [63:0] pv;
        if (mul) begin
            p     = longint'(signed'(a)) * longint'(signed'(b));
            pv    = p;
            r.res = pv[31:0];
            r.exc = (pv[63:32] != {32{pv[31]}});
        end else if (b == 32'h0) begin
            r.res = 32'h0;
            r.exc = 1'b1;
        end else begin
            p     = longint'(signed'(a)) / longint'(signed'(b));
            pv    = p;
            r.res = pv[31:0];
            r.exc = (p > 64'sd2147483647);
        end
        return r;
    endfunction

    // Entered at active edge + 1; watches 'win' cycles, scoring any ready pulse.
    task automatic observe(input int win, input int disturb_k, output int ready_cnt,
                           output int lat, output int stall_cnt);
        exp_t e;
        ready_cnt = 0;
        lat       = -1;
        stall_cnt = 0;
        for (int k = 0; k < win; k++) begin
            if (data_ready === 1'b1) begin
                ready_cnt++;
                if (lat < 0) lat = k;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready at cycle %0d expected none", k);
                end else begin
                    e = sb_q.pop_front();
                    check32("result", data_result, e.res);
                    check32("exception", {31'b0, data_exception}, {31'b0, e.exc});
                end
            end
            @(negedge clock);
            if (k == disturb_k) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd0;
            end
            #1;
            if (stall === 1'b1) stall_cnt++;
            @(posedge clock);
            #1;
            ctrl_DIV = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int disturb_k, input string name);
        int rc, lat, sc, stall_total;
        @(negedge clock);
        ctrl_MULT     = v.mul;
        ctrl_DIV      = v.div;
        data_operandA = v.a;
        data_operandB = v.b;
        sb_q.push_back('{v.res, v.exc});
        #1;
        stall_total = (stall === 1'b1) ? 1 : 0;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        observe(40, disturb_k, rc, lat, sc);
        stall_total += sc;
        $display("%s: mul=%b div=%b a=%h b=%h result=%h exc=%b latency=%0d stall=%0d",
                 name, v.mul, v.div, v.a, v.b, data_result, data_exception, lat, stall_total);
        check_int({name, " ready_pulses"}, rc, 1);
        check_int({name, " latency"}, lat, v.lat);
        check_int({name, " stall_cycles"}, stall_total, v.stl);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s missing_result: got no ready expected %h", name, v.res);
            sb_q.delete();
        end
    endtask

    vec_t tbl[15];

    initial begin
        int   rc, lat, sc;
        logic [4:0] op;
        vec_t v;
        exp_t e;

        tbl[0]  = mk(1, 0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        tbl[1]  = mk(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1);
        tbl[2]  = mk(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
        tbl[3]  = mk(1, 0, 32'h80000000, 32'h00000001, 32'h80000000, 0);
        tbl[4]  = mk(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        tbl[5]  = mk(1, 0, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1);
        tbl[6]  = mk(0, 1, 32'hFFFFFFEC, 32'h00000006, 32'hFFFFFFFD, 0);
        tbl[7]  = mk(0, 1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 0);
        tbl[8]  = mk(0, 1, 32'h00000064, 32'h00000007, 32'h0000000E, 0);
        tbl[9]  = mk(0, 1, 32'h80000000, 32'h00000002, 32'hC0000000, 0);
        tbl[10] = mk(0, 1, 32'h00000003, 32'h00000005, 32'h00000000, 0);
        tbl[11] = mk(0, 1, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000001, 0);
        tbl[12] = mk(0, 1, 32'h00000005, 32'h00000000, 32'h00000000, 1);
        tbl[13] = mk(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        tbl[14] = mk(1, 1, 32'h00000006, 32'h00000003, 32'h00000012, 0);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check32("reset result", data_result, 32'h0);
        check32("reset exception", {31'b0, data_exception}, 32'h0);
        check32("reset ready", {31'b0, data_ready}, 32'h0);
        check32("reset stall", {31'b0, stall}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(tbl[i], -1, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            op = ($urandom_range(0, 1) == 1) ? ALU_OP_MULT : ALU_OP_DIV;
            v.a = $urandom;
            v.b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            v.mul = (op == ALU_OP_MULT);
            v.div = (op == ALU_OP_DIV);
            e = model(v.mul, v.a, v.b);
            v = mk(v.mul, v.div, v.a, v.b, e.res, e.exc);
            run_vec(v, -1, $sformatf("rand%0d", i));
        end

        // Divide-by-zero start pulse injected mid-multiply must be ignored
        run_vec(tbl[0], 3, "busy_start");

        // Reset in the middle of a multiply
        run_vec(tbl[13], -1, "pre_reset");
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'h7; data_operandB = 32'hFFFFFFFD;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        #1;
        check32("mid_op result_hold", data_result, 32'h80000000);
        check32("mid_op stall", {31'b0, stall}, 32'h1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check32("midreset result", data_result, 32'h0);
        check32("midreset exception", {31'b0, data_exception}, 32'h0);
        check32("midreset ready", {31'b0, data_ready}, 32'h0);
        check32("midreset stall", {31'b0, stall}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        observe(40, -1, rc, lat, sc);
        $display("reset_abort: ready_pulses=%0d stall=%0d", rc, sc);
        check_int("reset_abort ready_pulses", rc, 0);
        check_int("reset_abort stall_cycles", sc, 0);

        // Flush in the middle of a divide
        run_vec(tbl[14], -1, "pre_flush");
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        #1;
        check32("flush_cycle stall", {31'b0, stall}, 32'h1);
        @(posedge clock);
        #1;
        flush = 1'b0;
        check32("after_flush stall", {31'b0, stall}, 32'h0);
        check32("after_flush ready", {31'b0, data_ready}, 32'h0);
        observe(40, -1, rc, lat, sc);
        $display("flush_abort: ready_pulses=%0d stall=%0d result=%h", rc, sc, data_result);
        check_int("flush_abort ready_pulses", rc, 0);
        check_int("flush_abort stall_cycles", sc, 0);
        check32("flush_abort result_hold", data_result, 32'h12);

        // Flush together with a start suppresses the start
        @(negedge clock);
        ctrl_MULT = 1'b1; flush = 1'b1; data_operandA = 32'd5; data_operandB = 32'd5;
        #1;
        check32("flush_start stall", {31'b0, stall}, 32'h0);
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0; flush = 1'b0;
        observe(40, -1, rc, lat, sc);
        $display("flush_start: ready_pulses=%0d stall=%0d result=%h", rc, sc, data_result);
        check_int("flush_start ready_pulses", rc, 0);
        check_int("flush_start stall_cycles", sc, 0);
        check32("flush_start result_hold", data_result, 32'h12);

        run_vec(tbl[8], -1, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
